// File: rtl/fifo_cell_array_pkg.sv
// Shared constants for the cell-array FIFO and its helpers.
package fifo_cell_array_pkg;

  // Default geometry, also used by the external full detector.
  localparam int N_CELLS_DEF    = 16;
  localparam int DATA_WIDTH_DEF = 8;

endpackage : fifo_cell_array_pkg

// File: rtl/fifo_cell_array_cell.sv
// One FIFO storage cell: a data word plus its occupied flag.
module fifo_cell_array_cell #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  put_en,
  input  logic                  get_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full_o
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Occupied flag: set on write, cleared on read. A cell never sees both
  // in the same cycle because the tokens only coincide when empty or full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (put_en) begin
      full_q <= 1'b1;
    end else if (get_en) begin
      full_q <= 1'b0;
    end
  end

  // Stored word; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (put_en) begin
      data_q <= data_in;
    end
  end

  assign data_out = data_q;
  assign full_o   = full_q;

endmodule : fifo_cell_array_cell

// File: rtl/fifo_cell_array.sv
// Circular FIFO built from independent cells, steered by one-hot put/get tokens.
module fifo_cell_array
  import fifo_cell_array_pkg::*;
#(
  parameter int N_CELLS    = N_CELLS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  put,
  input  logic [DATA_WIDTH-1:0] data_put,
  input  logic                  get,
  output logic [DATA_WIDTH-1:0] data_get,
  output logic                  valid_get,
  output logic [N_CELLS-1:0]    f_o,
  output logic                  empty,
  output logic                  overflow
);

  localparam logic [N_CELLS-1:0] TOK_INIT = {{(N_CELLS-1){1'b0}}, 1'b1};

  logic [N_CELLS-1:0]    put_tok_q, put_tok_d;
  logic [N_CELLS-1:0]    get_tok_q, get_tok_d;
  logic [N_CELLS-1:0]    put_en, get_en;
  logic [DATA_WIDTH-1:0] cell_data [N_CELLS];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] data_get_q, data_get_d;
  logic                  valid_get_q, valid_get_d;
  logic                  overflow_q, overflow_d;
  logic                  full_int, put_ok, get_ok;

  // Status derived from the registered per-cell flags (pre-edge state).
  assign full_int = &f_o;
  assign empty    = ~|f_o;
  assign put_ok   = put & ~full_int;
  assign get_ok   = get & ~empty;

  // Cell array; each cell is enabled by its own token bit.
  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    assign put_en[gi] = put_ok & put_tok_q[gi];
    assign get_en[gi] = get_ok & get_tok_q[gi];

    fifo_cell_array_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .put_en   (put_en[gi]),
      .get_en   (get_en[gi]),
      .data_in  (data_put),
      .data_out (cell_data[gi]),
      .full_o   (f_o[gi])
    );
  end

  // One-hot read mux: OR together the word of the cell holding the get token.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (get_tok_q[i]) begin
        rd_data = rd_data | cell_data[i];
      end
    end
  end

  // Next-state for token rings, read port and sticky overflow.
  always_comb begin
    put_tok_d   = put_tok_q;
    get_tok_d   = get_tok_q;
    data_get_d  = data_get_q;
    valid_get_d = 1'b0;
    overflow_d  = overflow_q;
    if (put_ok) begin
      put_tok_d = {put_tok_q[N_CELLS-2:0], put_tok_q[N_CELLS-1]};
    end
    if (get_ok) begin
      get_tok_d   = {get_tok_q[N_CELLS-2:0], get_tok_q[N_CELLS-1]};
      data_get_d  = rd_data;
      valid_get_d = 1'b1;
    end
    if (put && full_int) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; reset returns both tokens to cell 0 and clears the read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      put_tok_q   <= TOK_INIT;
      get_tok_q   <= TOK_INIT;
      data_get_q  <= '0;
      valid_get_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      put_tok_q   <= put_tok_d;
      get_tok_q   <= get_tok_d;
      data_get_q  <= data_get_d;
      valid_get_q <= valid_get_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_get  = data_get_q;
  assign valid_get = valid_get_q;
  assign overflow  = overflow_q;

endmodule : fifo_cell_array

// File: tb/tb_fifo_cell_array.sv
// Self-checking bench: queue-based FIFO model compared every cycle, plus pinned literals.
module tb_fifo_cell_array;

  localparam int N  = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          put = 1'b0;
  logic          get = 1'b0;
  logic [DW-1:0] data_put = '0;
  logic [DW-1:0] data_get;
  logic          valid_get;
  logic [N-1:0]  f_o;
  logic          empty;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [DW-1:0] mq[$];
  int            m_head = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf = 1'b0;

  fifo_cell_array #(
    .N_CELLS    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .put       (put),
    .data_put  (data_put),
    .get       (get),
    .data_get  (data_get),
    .valid_get (valid_get),
    .f_o       (f_o),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Occupancy as a run of 1s starting at the oldest word's cell.
  function automatic logic [N-1:0] model_f();
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < mq.size(); k++) v[(m_head + k) % N] = 1'b1;
    return v;
  endfunction

  // Apply one clock edge worth of FIFO rules to the model (pre-edge decisions).
  task automatic model_step(input bit r, input bit p, input bit g, input logic [DW-1:0] d);
    bit was_full, was_empty;
    if (r) begin
      mq.delete();
      m_head  = 0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      was_full  = (mq.size() == N);
      was_empty = (mq.size() == 0);
      m_valid   = 1'b0;
      if (g && !was_empty) begin
        m_data  = mq.pop_front();
        m_head  = (m_head + 1) % N;
        m_valid = 1'b1;
      end
      if (p && !was_full) mq.push_back(d);
      if (p && was_full) m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("f_o", f_o, model_f());
    chk("empty", empty, mq.size() == 0);
    chk("valid_get", valid_get, m_valid);
    chk("data_get", data_get, m_data);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic cycle(input bit r, input bit p, input bit g, input logic [DW-1:0] d);
    reset    = r;
    put      = p;
    get      = g;
    data_put = d;
    @(posedge clk);
    model_step(r, p, g, d);
    #1;
    $display("cyc rst=%0d put=%0d get=%0d din=%h -> f=%h dout=%h v=%0d ovf=%0d",
             r, p, g, d, f_o, data_get, valid_get, overflow);
    compare_all();
  endtask

  initial begin
    // 1. reset then idle
    cycle(1, 0, 0, 8'h00);
    cycle(1, 1, 1, 8'h33);
    cycle(0, 0, 0, 8'h00);
    chk("lit_reset_f", f_o, 16'h0000);
    chk("lit_reset_empty", empty, 1);
    chk("lit_reset_dout", data_get, 8'h00);

    // 2. fill with 0x01..0x10
    for (int i = 1; i <= N; i++) cycle(0, 1, 0, DW'(i));
    chk("lit_full_f", f_o, 16'hFFFF);
    chk("lit_full_det", &f_o, 1);

    // 3. overflow put, then drain
    cycle(0, 1, 0, 8'hAA);
    chk("lit_ovf", overflow, 1);
    chk("lit_ovf_f", f_o, 16'hFFFF);
    cycle(0, 0, 1, 8'h00);
    chk("lit_first_get", data_get, 8'h01);
    for (int i = 1; i < N; i++) cycle(0, 0, 1, 8'h00);
    chk("lit_last_get", data_get, 8'h10);
    chk("lit_drained_empty", empty, 1);
    chk("lit_ovf_sticky", overflow, 1);

    // 4. wrap: move tokens to cell 15, then a two-word wrapped run
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < N - 1; i++) begin
      cycle(0, 1, 0, DW'(8'h40 + i));
      cycle(0, 0, 1, 8'h00);
    end
    cycle(0, 1, 0, 8'hC1);
    cycle(0, 1, 0, 8'hC2);
    chk("lit_wrap_f", f_o, 16'h8001);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, DW'(8'h60 + i));
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 1, 8'h00);
    chk("lit_wrap_last", data_get, 8'h73);

    // 5. simultaneous put&get when empty, then when full
    cycle(1, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h55);
    chk("lit_sim_empty_f", f_o, 16'h0001);
    chk("lit_sim_empty_v", valid_get, 0);
    for (int i = 1; i < N; i++) cycle(0, 1, 0, DW'(i));
    cycle(0, 1, 1, 8'h77);
    chk("lit_sim_full_d", data_get, 8'h55);
    chk("lit_sim_full_ovf", overflow, 1);

    // 6. reset mid-stream with 5 words and put&get active
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, DW'(8'h20 + i));
    cycle(1, 1, 1, 8'hEE);
    chk("lit_rst_mid_f", f_o, 16'h0000);
    chk("lit_rst_mid_v", valid_get, 0);
    cycle(0, 1, 0, 8'h99);
    chk("lit_rst_mid_cell0", f_o, 16'h0001);
    cycle(0, 0, 1, 8'h00);
    chk("lit_rst_mid_read", data_get, 8'h99);

    // Randomized phases with varying put/get bias and rare resets
    for (int blk = 0; blk < 8; blk++) begin
      int pp, gp;
      pp = $urandom_range(15, 90);
      gp = $urandom_range(15, 90);
      for (int c = 0; c < 250; c++) begin
        cycle(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < pp),
              ($urandom_range(0, 99) < gp),
              DW'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_cell_array
